// File: rtl/tick_sample_source_pkg.sv
// rtl/tick_sample_source_pkg.sv - shared constants and types for the tick sample source
//
// Purpose: LFSR tap mask, default seed, overrun counter width, generator mode
//          and output buffer occupancy types, plus the LFSR step function.
// Ports:   none (package)

package tick_sample_source_pkg;

   // Taps 16,14,13,11 of a right-shifting Fibonacci LFSR land on bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;
   localparam logic [15:0] DEFAULT_SEED  = 16'hACE1;
   localparam int          OVERRUN_W     = 16;

   typedef enum logic {
      GEN_RAMP = 1'b0,
      GEN_LFSR = 1'b1
   } gen_mode_e;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   // One LFSR step: feedback is the parity of the tapped bits, shifted in at the top.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {^(s & LFSR_TAP_MASK), s[15:1]};
   endfunction

endpackage

// File: rtl/tick_sample_source_if.sv
// rtl/tick_sample_source_if.sv - valid/ready sample stream interface
//
// Purpose: groups the sample stream handshake.
// Signals: sample [WIDTH-1:0] - sample value, driven by master
//          valid               - sample holds an undelivered value, driven by master
//          ready               - downstream accepts, driven by slave

interface tick_sample_source_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] sample;
   logic             valid;
   logic             ready;

   modport master (output sample, output valid, input ready);
   modport slave  (input sample, input valid, output ready);
endinterface

// File: rtl/tick_sample_source_lfsr16.sv
// rtl/tick_sample_source_lfsr16.sv - 16-bit Fibonacci LFSR with step enable
//
// Purpose: holds the LFSR state; advances one step on each enabled cycle.
// Ports:   clk   - system clock
//          rst   - asynchronous active-high reset, loads SEED
//          en    - advance one step this cycle
//          state - current 16-bit LFSR state

module lfsr16
   import tick_sample_source_pkg::*;
#(
   parameter logic [15:0] SEED = DEFAULT_SEED
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] state
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= SEED;
      end else if (en) begin
         state <= lfsr_next(state);
      end
   end

endmodule

// File: rtl/tick_sample_source.sv
// rtl/tick_sample_source.sv - tick-driven ramp/LFSR sample source with 2-deep output buffer
//
// Purpose: on each accepted tick (tick && en) generates one sample from the
//          ramp or LFSR generator and queues it in an output register plus one
//          pending register; samples arriving with both full are dropped and
//          counted in a saturating overrun counter.
// Ports:   clk         - system clock
//          rst         - asynchronous active-high reset
//          tick        - one-cycle sample request pulse
//          en          - tick enable
//          mode        - 0 ramp, 1 LFSR (sampled on the tick cycle)
//          overrun_cnt - saturating count of dropped samples
//          bus         - sample/valid/ready stream (master side)

module tick_sample_source
   import tick_sample_source_pkg::*;
#(
   parameter int          WIDTH = 8,
   parameter logic [15:0] SEED  = DEFAULT_SEED
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 en,
   input  logic                 mode,
   output logic [OVERRUN_W-1:0] overrun_cnt,
   tick_sample_source_if.master bus
);

   logic        acc_tick;
   logic        xfer;
   logic        sel_lfsr;
   logic [15:0] ramp_q;
   logic [15:0] lfsr_state;
   logic [15:0] gen_full;
   logic        unused_gen_bits;

   logic [WIDTH-1:0] sample_q;
   logic [WIDTH-1:0] pend_q;
   logic             valid_q;

   buf_state_e buf_q;
   buf_state_e buf_next;
   logic       load_out;
   logic       out_from_pend;
   logic       load_pend;
   logic       drop;

   assign acc_tick = tick && en;
   assign sel_lfsr = (mode == GEN_LFSR);
   assign xfer     = valid_q && bus.ready;

   // Emitted value is the generator state before it advances.
   assign gen_full        = sel_lfsr ? lfsr_state : ramp_q;
   assign unused_gen_bits = ^gen_full;

   lfsr16 #(
      .SEED (SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (acc_tick && sel_lfsr),
      .state (lfsr_state)
   );

   // Ramp advances even when its sample is later dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ramp_q <= 16'h0000;
      end else if (acc_tick && !sel_lfsr) begin
         ramp_q <= ramp_q + 16'd1;
      end
   end

   // Buffer occupancy: next state and datapath controls.
   always_comb begin
      buf_next      = buf_q;
      load_out      = 1'b0;
      out_from_pend = 1'b0;
      load_pend     = 1'b0;
      drop          = 1'b0;
      case (buf_q)
         BUF_EMPTY: begin
            if (acc_tick) begin
               load_out = 1'b1;
               buf_next = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (xfer && acc_tick) begin
               load_out = 1'b1;
            end else if (xfer) begin
               buf_next = BUF_EMPTY;
            end else if (acc_tick) begin
               load_pend = 1'b1;
               buf_next  = BUF_TWO;
            end
         end
         BUF_TWO: begin
            if (xfer) begin
               // Pending always moves up first so FIFO order holds.
               load_out      = 1'b1;
               out_from_pend = 1'b1;
               if (acc_tick) begin
                  load_pend = 1'b1;
               end else begin
                  buf_next = BUF_ONE;
               end
            end else if (acc_tick) begin
               drop = 1'b1;
            end
         end
         default: begin
            buf_next = BUF_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q    <= BUF_EMPTY;
         valid_q  <= 1'b0;
         sample_q <= '0;
         pend_q   <= '0;
      end else begin
         buf_q   <= buf_next;
         valid_q <= (buf_next != BUF_EMPTY);
         if (load_out) begin
            sample_q <= out_from_pend ? pend_q : gen_full[WIDTH-1:0];
         end
         if (load_pend) begin
            pend_q <= gen_full[WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun_cnt <= '0;
      end else if (drop && (overrun_cnt != {OVERRUN_W{1'b1}})) begin
         overrun_cnt <= overrun_cnt + 1'b1;
      end
   end

   assign bus.sample = sample_q;
   assign bus.valid  = valid_q;

endmodule

// File: tb/tb_tick_sample_source.sv
// tb/tb_tick_sample_source.sv - self-checking bench for tick_sample_source

module tb_tick_sample_source;

   localparam int W = 16;

   logic        clk;
   logic        rst;
   logic        tick;
   logic        en;
   logic        mode;
   logic [15:0] overrun_cnt;

   int n_checks;
   int n_fail;

   tick_sample_source_if #(.WIDTH(W)) bus ();

   tick_sample_source #(
      .WIDTH (W),
      .SEED  (16'hACE1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .en          (en),
      .mode        (mode),
      .overrun_cnt (overrun_cnt),
      .bus         (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic        tick;
      logic        en;
      logic        mode;
      logic        ready;
      logic        exp_valid;
      logic [15:0] exp_sample;
      logic [15:0] exp_ovr;
   } vec_t;

   vec_t vecs [19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      tick = 1'b0;
      en = 1'b1;
      mode = 1'b0;
      bus.ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
      logic fb;
      fb = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {fb, s[15:1]};
   endfunction

   initial begin
      logic [15:0] model;
      n_checks = 0;
      n_fail = 0;

      // Rows: tick, en, mode, ready -> valid, sample, overrun_cnt after the edge.
      vecs[0]  = '{1, 1, 0, 0, 1, 16'h0000, 16'd0};
      vecs[1]  = '{1, 1, 0, 0, 1, 16'h0000, 16'd0};
      vecs[2]  = '{1, 1, 0, 0, 1, 16'h0000, 16'd1};
      vecs[3]  = '{1, 1, 0, 0, 1, 16'h0000, 16'd2};
      vecs[4]  = '{0, 1, 0, 1, 1, 16'h0001, 16'd2};
      vecs[5]  = '{0, 1, 0, 1, 0, 16'h0001, 16'd2};
      vecs[6]  = '{1, 1, 0, 1, 1, 16'h0004, 16'd2};
      vecs[7]  = '{1, 1, 0, 0, 1, 16'h0004, 16'd2};
      vecs[8]  = '{1, 1, 0, 1, 1, 16'h0005, 16'd2};
      vecs[9]  = '{0, 1, 0, 1, 1, 16'h0006, 16'd2};
      vecs[10] = '{0, 1, 0, 1, 0, 16'h0006, 16'd2};
      vecs[11] = '{1, 1, 1, 1, 1, 16'hACE1, 16'd2};
      vecs[12] = '{1, 1, 1, 1, 1, 16'h5670, 16'd2};
      vecs[13] = '{1, 1, 1, 1, 1, 16'hAB38, 16'd2};
      vecs[14] = '{1, 1, 0, 1, 1, 16'h0007, 16'd2};
      vecs[15] = '{1, 0, 0, 1, 0, 16'h0007, 16'd2};
      vecs[16] = '{1, 0, 1, 1, 0, 16'h0007, 16'd2};
      vecs[17] = '{1, 1, 1, 1, 1, 16'h559C, 16'd2};
      vecs[18] = '{1, 1, 0, 1, 1, 16'h0008, 16'd2};

      // Reset state
      do_reset();
      check("reset_valid", {31'd0, bus.valid}, 32'd0);
      check("reset_sample", {16'd0, bus.sample}, 32'd0);
      check("reset_overrun", {16'd0, overrun_cnt}, 32'd0);

      // Table: backpressure/drops, simultaneous transfer+tick, mode switching, en gating
      for (int i = 0; i < 19; i++) begin
         tick = vecs[i].tick;
         en = vecs[i].en;
         mode = vecs[i].mode;
         bus.ready = vecs[i].ready;
         step();
         check($sformatf("vec%0d_valid", i), {31'd0, bus.valid}, {31'd0, vecs[i].exp_valid});
         if (vecs[i].exp_valid)
            check($sformatf("vec%0d_sample", i), {16'd0, bus.sample}, {16'd0, vecs[i].exp_sample});
         check($sformatf("vec%0d_overrun", i), {16'd0, overrun_cnt}, {16'd0, vecs[i].exp_ovr});
      end

      // Ramp, ready=1, tick every 10 cycles
      do_reset();
      bus.ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick = 1'b1;
         step();
         tick = 1'b0;
         check($sformatf("ramp%0d_valid", k), {31'd0, bus.valid}, 32'd1);
         check($sformatf("ramp%0d_sample", k), {16'd0, bus.sample}, k);
         step();
         check($sformatf("ramp%0d_drained", k), {31'd0, bus.valid}, 32'd0);
         for (int j = 0; j < 8; j++) step();
      end

      // LFSR against reference model
      do_reset();
      bus.ready = 1'b1;
      mode = 1'b1;
      model = 16'hACE1;
      for (int k = 0; k < 3; k++) begin
         tick = 1'b1;
         step();
         check($sformatf("lfsr%0d_sample", k), {16'd0, bus.sample}, {16'd0, model});
         model = ref_lfsr(model);
      end
      tick = 1'b0;

      // Reset while valid and pending full
      do_reset();
      tick = 1'b1;
      step();
      step();
      tick = 1'b0;
      bus.ready = 1'b1;
      check("prerst_valid", {31'd0, bus.valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_valid", {31'd0, bus.valid}, 32'd0);
      check("rst_async_sample", {16'd0, bus.sample}, 32'd0);
      step();
      check("rst_hold_valid", {31'd0, bus.valid}, 32'd0);
      rst = 1'b0;
      tick = 1'b1;
      step();
      tick = 1'b0;
      check("postrst_valid", {31'd0, bus.valid}, 32'd1);
      check("postrst_sample", {16'd0, bus.sample}, 32'd0);
      step();
      check("postrst_drained", {31'd0, bus.valid}, 32'd0);

      // Overrun saturation: 2 ticks fill the buffer, the rest are drops
      do_reset();
      tick = 1'b1;
      for (int k = 0; k < 65536; k++) @(posedge clk);
      #1;
      check("ovr_fffe", {16'd0, overrun_cnt}, 32'h0000FFFE);
      step();
      check("ovr_ffff", {16'd0, overrun_cnt}, 32'h0000FFFF);
      for (int k = 0; k < 4; k++) step();
      check("ovr_saturated", {16'd0, overrun_cnt}, 32'h0000FFFF);
      check("ovr_sample_held", {16'd0, bus.sample}, 32'd0);
      tick = 1'b0;
      bus.ready = 1'b1;
      step();
      check("ovr_pending", {16'd0, bus.sample}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
